mul_32bit: RTL and testbench

MUL_32BIT -- requirements
Module: mul_32bit

---
 rtl/mul_32bit_if.sv | 25 ++
 rtl/mul_32bit.sv | 98 +++++++++
 tb/tb_mul_32bit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mul_32bit_if.sv
// mul_32bit_if -- operand/product bus for the pipelined signed multiplier.
//   in_valid : qualifies a/b in the current cycle (no backpressure)
//   a, b     : signed operands, WIDTH bits
//   out_valid: one-cycle strobe, p holds the matching product
//   p        : signed product, 2*WIDTH bits
// master drives operands and observes results; slave is the multiplier.
interface mul_32bit_if #(
  parameter int WIDTH = 32
);
  logic                   in_valid;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   out_valid;
  logic [2*WIDTH-1:0]     p;

  modport master (
    output in_valid, a, b,
    input  out_valid, p
  );

  modport slave (
    input  in_valid, a, b,
    output out_valid, p
  );
endinterface

// File: rtl/mul_32bit.sv
// mul_32bit -- two-stage pipelined signed multiplier, p = a * b (64-bit exact).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears every pipeline register
//   bus   : mul_32bit_if slave (in_valid/a/b in, out_valid/p out)
// Stage 1: radix-4 Booth recoding of b into 17 partial products, reduced by
//          a carry-save chain to a sum/carry pair that is registered.
// Stage 2: carry-propagate add of the pair into p.
// Only WIDTH = 32 is supported.
module mul_32bit #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  mul_32bit_if.slave  bus
);
  localparam int PW  = 2 * WIDTH;
  localparam int NPP = (WIDTH + 2) / 2;

  logic [PW-1:0]  w_a_ext;
  logic [WIDTH+2:0] w_b_ext;
  logic [PW-1:0]  w_sum;
  logic [PW-1:0]  w_carry;

  logic           r_v1;
  logic [PW-1:0]  r_sum;
  logic [PW-1:0]  r_carry;
  logic           r_v2;
  logic [PW-1:0]  r_p;

  // b sign-extended to WIDTH+2 bits with the implicit zero below the LSB,
  // so every Booth group is a plain 3-bit slice.
  assign w_a_ext = {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
  assign w_b_ext = {bus.b[WIDTH-1], bus.b[WIDTH-1], bus.b, 1'b0};

  always_comb begin : booth_csa
    logic [PW-1:0] v_mag;
    logic [PW-1:0] v_pp;
    logic [PW-1:0] v_s;
    logic [PW-1:0] v_c;
    logic [PW-1:0] v_ns;
    logic [PW-1:0] v_nc;
    v_mag = '0;
    v_pp  = '0;
    v_s   = '0;
    v_c   = '0;
    v_ns  = '0;
    v_nc  = '0;
    for (int i = 0; i < NPP; i++) begin
      case (w_b_ext[2*i +: 3])
        3'b001, 3'b010: v_mag = w_a_ext;
        3'b011:         v_mag = w_a_ext << 1;
        3'b100:         v_mag = -(w_a_ext << 1);
        3'b101, 3'b110: v_mag = -w_a_ext;
        default:        v_mag = '0;
      endcase
      v_pp = v_mag << (2 * i);
      if (i == 0) begin
        v_s = v_pp;
      end else if (i == 1) begin
        v_c = v_pp;
      end else begin
        // 3:2 compression; the carry bit shifted out of the top is beyond
        // the 64-bit result and is correctly dropped (mod 2^64 arithmetic).
        v_ns = v_s ^ v_c ^ v_pp;
        v_nc = ((v_s & v_c) | (v_s & v_pp) | (v_c & v_pp)) << 1;
        v_s  = v_ns;
        v_c  = v_nc;
      end
    end
    w_sum   = v_s;
    w_carry = v_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_sum   <= '0;
      r_carry <= '0;
      r_v2    <= 1'b0;
      r_p     <= '0;
    end else begin
      r_v1 <= bus.in_valid;
      r_v2 <= r_v1;
      if (bus.in_valid) begin
        r_sum   <= w_sum;
        r_carry <= w_carry;
      end
      // p only moves when a real product arrives, otherwise it holds.
      if (r_v1) begin
        r_p <= r_sum + r_carry;
      end
    end
  end

  assign bus.out_valid = r_v2;
  assign bus.p         = r_p;
endmodule

// File: tb/tb_mul_32bit.sv
module tb_mul_32bit;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mul_32bit_if #(.WIDTH(32)) bus ();
  mul_32bit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [63:0] sb_q[$];
  logic [1:0]  m_v;
  logic [63:0] last_p = '0;
  logic [63:0] mon_exp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference valid pipeline: in_valid delayed two edges, cleared by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_v <= 2'b00;
    else        m_v <= {m_v[0], bus.in_valid};
  end

  // Output monitor: sample on falling edge, pop scoreboard on each result.
  always @(negedge clk) begin
    if (!rst_n) last_p = '0;
    chk("out_valid", {63'd0, bus.out_valid}, {63'd0, m_v[1]});
    if (bus.out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result", 64'd1, 64'd0);
      end else begin
        mon_exp = sb_q.pop_front();
        last_p  = mon_exp;
        chk("product", bus.p, mon_exp);
      end
    end else begin
      chk("p_hold", bus.p, last_p);
    end
  end

  task automatic drive(input logic v, input logic [31:0] ta, input logic [31:0] tb_);
    logic signed [63:0] x;
    logic signed [63:0] y;
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.a        = ta;
    bus.b        = tb_;
    if (v) begin
      x = {{32{ta[31]}}, ta};
      y = {{32{tb_[31]}}, tb_};
      sb_q.push_back(x * y);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    #2;
    chk("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("reset_p", bus.p, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // First operands right after reset release; explicit latency checks.
    drive(1'b1, 32'd8, 32'd125);
    drive(1'b0, 32'd0, 32'd0);
    @(posedge clk);
    #2;
    chk("basic_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("basic_p", bus.p, 64'd1000);
    @(posedge clk);
    #2;
    chk("basic_valid_drop", {63'd0, bus.out_valid}, 64'd0);
    chk("basic_p_hold", bus.p, 64'h3E8);
    idle(2);

    drive(1'b1, 32'd225, 32'd30);
    idle(3);
    chk("basic2_p", bus.p, 64'h1A5E);

    drive(1'b1, 32'hFFFF_FFF8, 32'd125);
    idle(3);
    chk("neg8x125", bus.p, 64'hFFFF_FFFF_FFFF_FC18);

    // Back-to-back corners.
    drive(1'b1, 32'h8000_0000, 32'h8000_0000);
    drive(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    drive(1'b1, 32'h8000_0000, 32'd1);
    drive(1'b1, 32'h1234_5678, 32'd0);
    drive(1'b1, 32'd0, 32'hFFFF_FFFF);
    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drive(1'b1, 32'h7FFF_FFFF, 32'h8000_0000);
    idle(3);
    chk("last_corner_p", bus.p, 64'hC000_0000_8000_0000);

    // Streaming random operands, one per cycle.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom();
      rb = $urandom();
      if (i % 97 == 0) ra = 32'h8000_0000;
      if (i % 89 == 0) rb = 32'h7FFF_FFFF;
      drive(1'b1, ra, rb);
    end
    idle(4);

    // Reset while a product is in flight.
    drive(1'b1, 32'd8, 32'd125);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    sb_q.delete();
    #1;
    chk("midreset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("midreset_p", bus.p, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(6);
    chk("post_reset_p", bus.p, 64'd0);

    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
